exec_controller: RTL and testbench

- Sequences the CPU's `enable` input in place of the raw rate pulse from `enable_gen`.
- Supports free-run, single-step, halt and a single instruction-pointer breakpoint, driven by synchronised push buttons.
- Counts instructions issued for display and debug.
- Sits in `soc` between `enable_gen` (`tick_in`), the `gpi_sync` buttons, and `cpu.enable`/`cpu.instruction_pointer`.

---
 rtl/exec_controller.sv | 150 +++++++++++++++
 tb/tb_exec_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/exec_controller.sv
// exec_controller: gates the CPU execute enable from the rate tick.
// It supports free-run, single-step, halt and one instruction-pointer breakpoint,
// and counts the execute pulses it issues.
module exec_controller #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tick_in,
  input  logic              run_btn,
  input  logic              step_btn,
  input  logic              halt_btn,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] ip,
  output logic              cpu_enable,
  output logic [1:0]        state,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_STEP  = 2'b10;
  localparam logic [1:0] S_BREAK = 2'b11;

  logic       run_q;
  logic       step_q;
  logic       halt_q;
  logic       run_edge;
  logic       step_edge;
  logic       halt_edge;
  logic       skip_bp;
  logic       skip_bp_nx;
  logic       bp_match;
  logic       pulse;
  logic [1:0] state_nx;

  // Button history; reset to 1 so a button held through reset gives no edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q  <= 1'b1;
      step_q <= 1'b1;
      halt_q <= 1'b1;
    end else begin
      run_q  <= run_btn;
      step_q <= step_btn;
      halt_q <= halt_btn;
    end
  end

  assign run_edge  = run_btn  & ~run_q;
  assign step_edge = step_btn & ~step_q;
  assign halt_edge = halt_btn & ~halt_q;

  // The breakpoint instruction is let through once after resuming from BREAK.
  assign bp_match = bp_en && (ip == bp_addr) && !skip_bp;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; halt outranks run, which outranks step.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (halt_edge) begin
          state_nx = S_IDLE;
        end else if (run_edge) begin
          state_nx = S_RUN;
        end else if (step_edge) begin
          state_nx = S_STEP;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        if (halt_edge) begin
          state_nx = S_IDLE;
        end else if (tick_in && bp_match) begin
          state_nx = S_BREAK;
        end else begin
          state_nx = S_RUN;
        end
      end
      S_STEP: begin
        if (halt_edge || tick_in) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_STEP;
        end
      end
      S_BREAK: begin
        if (halt_edge) begin
          state_nx = S_IDLE;
        end else if (run_edge) begin
          state_nx = S_RUN;
        end else if (step_edge) begin
          state_nx = S_STEP;
        end else begin
          state_nx = S_BREAK;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode: execute pulse request and next breakpoint-skip flag.
  always_comb begin
    pulse = 1'b0;
    case (state)
      S_IDLE:  pulse = 1'b0;
      S_RUN:   pulse = !halt_edge && tick_in && !bp_match;
      S_STEP:  pulse = !halt_edge && tick_in;
      S_BREAK: pulse = 1'b0;
      default: pulse = 1'b0;
    endcase

    if (pulse || (state_nx == S_IDLE)) begin
      skip_bp_nx = 1'b0;
    end else if ((state == S_BREAK) && (state_nx == S_RUN)) begin
      skip_bp_nx = 1'b1;
    end else begin
      skip_bp_nx = skip_bp;
    end
  end

  // Registered outputs and the wrapping instruction counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cpu_enable  <= 1'b0;
      bp_hit      <= 1'b0;
      skip_bp     <= 1'b0;
      instr_count <= {CNT_W{1'b0}};
    end else begin
      cpu_enable  <= pulse;
      bp_hit      <= (state_nx == S_BREAK);
      skip_bp     <= skip_bp_nx;
      instr_count <= instr_count + {{(CNT_W-1){1'b0}}, pulse};
    end
  end

endmodule

// File: tb/tb_exec_controller.sv
// Directed, table-driven bench for exec_controller.
module tb_exec_controller;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tick_in = 1'b0;
  logic        run_btn = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_btn = 1'b0;
  logic        bp_en = 1'b0;
  logic [7:0]  bp_addr = 8'h04;
  logic [7:0]  ip = 8'h00;
  logic        cpu_enable;
  logic [1:0]  state;
  logic        bp_hit;
  logic [15:0] instr_count;
  logic        cpu_enable_s;
  logic [1:0]  state_s;
  logic        bp_hit_s;
  logic [3:0]  instr_count_s;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  exec_controller dut (
    .clk(clk), .resetn(resetn), .tick_in(tick_in), .run_btn(run_btn),
    .step_btn(step_btn), .halt_btn(halt_btn), .bp_en(bp_en), .bp_addr(bp_addr),
    .ip(ip), .cpu_enable(cpu_enable), .state(state), .bp_hit(bp_hit),
    .instr_count(instr_count)
  );

  // Narrow counter instance to reach the wrap boundary in a few cycles.
  exec_controller #(.ADDR_W(8), .CNT_W(4)) dut_small (
    .clk(clk), .resetn(resetn), .tick_in(tick_in), .run_btn(run_btn),
    .step_btn(step_btn), .halt_btn(halt_btn), .bp_en(bp_en), .bp_addr(bp_addr),
    .ip(ip), .cpu_enable(cpu_enable_s), .state(state_s), .bp_hit(bp_hit_s),
    .instr_count(instr_count_s)
  );

  typedef struct {
    logic        run;
    logic        step;
    logic        halt;
    logic        tick;
    logic        bpe;
    logic [7:0]  bpa;
    logic [7:0]  ipv;
    logic [1:0]  e_state;
    logic        e_en;
    logic        e_hit;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic h, input logic t,
                     input logic be, input logic [7:0] ba, input logic [7:0] iv,
                     input logic [1:0] es, input logic een, input logic eh,
                     input logic [15:0] ec);
    vec_t v;
    v.run = r; v.step = s; v.halt = h; v.tick = t; v.bpe = be; v.bpa = ba;
    v.ipv = iv; v.e_state = es; v.e_en = een; v.e_hit = eh; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then sample just after the rising edge.
  task automatic cyc(input logic r, input logic s, input logic h, input logic t,
                     input logic be, input logic [7:0] iv);
    @(negedge clk);
    run_btn = r; step_btn = s; halt_btn = h; tick_in = t; bp_en = be; ip = iv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Test 1: free run, five ticks.
    add(0,0,0,0, 0,8'h04,8'h00, 2'd0,0,0,16'd0);
    add(1,0,0,0, 0,8'h04,8'h00, 2'd1,0,0,16'd0);
    for (int k = 1; k <= 5; k++) begin
      add(1,0,0,1, 0,8'h04,8'h00, 2'd1,1,0,16'(k));
      add(1,0,0,0, 0,8'h04,8'h00, 2'd1,0,0,16'(k));
    end
    add(0,0,0,0, 0,8'h04,8'h00, 2'd1,0,0,16'd5);
    // Test 4: halt + run + tick together -> IDLE, no pulse.
    add(1,0,1,1, 0,8'h04,8'h00, 2'd0,0,0,16'd5);
    add(0,0,0,0, 0,8'h04,8'h00, 2'd0,0,0,16'd5);
    // Test 2: single step, held button gives one pulse only.
    add(0,1,0,0, 0,8'h04,8'h00, 2'd2,0,0,16'd5);
    add(0,1,0,1, 0,8'h04,8'h00, 2'd0,1,0,16'd6);
    add(0,1,0,0, 0,8'h04,8'h00, 2'd0,0,0,16'd6);
    add(0,1,0,1, 0,8'h04,8'h00, 2'd0,0,0,16'd6);
    add(0,1,0,0, 0,8'h04,8'h00, 2'd0,0,0,16'd6);
    add(0,1,0,1, 0,8'h04,8'h00, 2'd0,0,0,16'd6);
    add(0,0,0,0, 0,8'h04,8'h00, 2'd0,0,0,16'd6);
    // Halt while waiting in STEP cancels the step.
    add(0,1,0,0, 0,8'h04,8'h00, 2'd2,0,0,16'd6);
    add(0,1,1,0, 0,8'h04,8'h00, 2'd0,0,0,16'd6);
    add(0,0,0,1, 0,8'h04,8'h00, 2'd0,0,0,16'd6);
    add(0,0,0,0, 0,8'h04,8'h00, 2'd0,0,0,16'd6);
    // Test 3: breakpoint, resume past it, break again, step out of BREAK.
    add(1,0,0,0, 1,8'h04,8'h03, 2'd1,0,0,16'd6);
    add(1,0,0,1, 1,8'h04,8'h03, 2'd1,1,0,16'd7);
    add(1,0,0,0, 1,8'h04,8'h04, 2'd1,0,0,16'd7);
    add(1,0,0,1, 1,8'h04,8'h04, 2'd3,0,1,16'd7);
    add(0,0,0,0, 1,8'h04,8'h04, 2'd3,0,1,16'd7);
    add(0,0,0,1, 1,8'h04,8'h04, 2'd3,0,1,16'd7);
    add(1,0,0,0, 1,8'h04,8'h04, 2'd1,0,0,16'd7);
    add(1,0,0,1, 1,8'h04,8'h04, 2'd1,1,0,16'd8);
    add(1,0,0,0, 1,8'h04,8'h05, 2'd1,0,0,16'd8);
    add(1,0,0,1, 1,8'h04,8'h05, 2'd1,1,0,16'd9);
    add(1,0,0,0, 1,8'h04,8'h04, 2'd1,0,0,16'd9);
    add(1,0,0,1, 1,8'h04,8'h04, 2'd3,0,1,16'd9);
    add(0,1,0,0, 1,8'h04,8'h04, 2'd2,0,0,16'd9);
    add(0,1,0,1, 1,8'h04,8'h04, 2'd0,1,0,16'd10);
    add(0,0,0,0, 0,8'h04,8'h00, 2'd0,0,0,16'd10);
    // Priority in IDLE: run beats step; halt in RUN with held buttons.
    add(1,1,0,0, 0,8'h04,8'h00, 2'd1,0,0,16'd10);
    add(1,1,1,0, 0,8'h04,8'h00, 2'd0,0,0,16'd10);
    add(0,0,0,0, 0,8'h04,8'h00, 2'd0,0,0,16'd10);

    // Reset state, checked while reset is asserted.
    #25;
    chk("reset state", 32'(state), 32'd0);
    chk("reset cpu_enable", 32'(cpu_enable), 32'd0);
    chk("reset bp_hit", 32'(bp_hit), 32'd0);
    chk("reset instr_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      run_btn = vecs[i].run; step_btn = vecs[i].step; halt_btn = vecs[i].halt;
      tick_in = vecs[i].tick; bp_en = vecs[i].bpe; bp_addr = vecs[i].bpa; ip = vecs[i].ipv;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].e_state));
      chk($sformatf("vec%0d cpu_enable", i), 32'(cpu_enable), 32'(vecs[i].e_en));
      chk($sformatf("vec%0d bp_hit", i), 32'(bp_hit), 32'(vecs[i].e_hit));
      chk($sformatf("vec%0d instr_count", i), 32'(instr_count), 32'(vecs[i].e_cnt));
    end

    // Test 6: asynchronous reset during a pulse with run held.
    cyc(1,0,0,0, 0,8'h00);
    chk("t6 run entered", 32'(state), 32'd1);
    cyc(1,0,0,1, 0,8'h00);
    chk("t6 pulse high", 32'(cpu_enable), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t6 async cpu_enable", 32'(cpu_enable), 32'd0);
    chk("t6 async state", 32'(state), 32'd0);
    chk("t6 async count", 32'(instr_count), 32'd0);
    chk("t6 async bp_hit", 32'(bp_hit), 32'd0);
    @(negedge clk);
    tick_in = 1'b0;
    resetn = 1'b1;
    cyc(1,0,0,0, 0,8'h00);
    cyc(1,0,0,1, 0,8'h00);
    chk("t6 held run no entry", 32'(state), 32'd0);
    chk("t6 held run no pulse", 32'(cpu_enable), 32'd0);
    cyc(0,0,0,0, 0,8'h00);
    cyc(1,0,0,0, 0,8'h00);
    chk("t6 re-press run", 32'(state), 32'd1);

    // Test 5: counter wrap, seen on the 4-bit instance after 16 pulses.
    for (int k = 1; k <= 15; k++) begin
      cyc(1,0,0,1, 0,8'h00);
      cyc(1,0,0,0, 0,8'h00);
    end
    chk("t5 small at max", 32'(instr_count_s), 32'hF);
    cyc(1,0,0,1, 0,8'h00);
    chk("t5 small wrapped", 32'(instr_count_s), 32'h0);
    chk("t5 wide count", 32'(instr_count), 32'd16);
    chk("t5 pulse on wrap", 32'(cpu_enable_s), 32'd1);
    cyc(0,0,0,0, 0,8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
